// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory / I/O responder.
//   IO_BASE  : UART data register (read pops RX, write pushes TX)
//   IO_STOP  : stop register (write queues 0x00 and raises halt); when the
//              CYCLE_COUNTER_EN macro is defined, reads of IO_STOP..IO_STOP+3
//              return the little-endian cycle-counter snapshot.
// decode_io_reg() classifies an 18-bit decoded address inside I/O space.
package mem_io_responder_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] IO_STOP = 32'h0003_0004;

    // mem_a[17:16] value that selects I/O space
    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        IO_RX    = 2'd0,  // exactly IO_BASE
        IO_CTR   = 2'd1,  // IO_STOP .. IO_STOP+3 (4-byte window)
        IO_OTHER = 2'd2   // every other I/O address
    } io_reg_e;

    function automatic io_reg_e decode_io_reg(input logic [17:0] off);
        io_reg_e r;
        if (off == IO_BASE[17:0]) begin
            r = IO_RX;
        end else if (off[17:2] == IO_STOP[17:2]) begin
            r = IO_CTR;
        end else begin
            r = IO_OTHER;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_ram.sv
// byte_ram: single-port byte RAM, synchronous write, registered read.
//   clk_in, rst_in : clock, async active-high reset (read register only;
//                    the array itself is never cleared)
//   we, re         : write enable / read enable for this cycle
//   addr, wdata    : byte address and write data
//   rdata          : read data, valid the cycle after re; holds otherwise
module byte_ram #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only moves on a read, so it holds across writes/stalls.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus UART-style I/O registers for a simple CPU.
//   clk_in, rst_in        : clock, async active-high reset
//   mem_a/mem_wr/mem_dout : CPU request (address, 1=write, write data)
//   mem_din               : registered read data (valid the cycle after a read)
//   rdy_out               : low while the TX FIFO is full; CPU holds its request
//   rx_data/rx_valid/rx_pop : UART receive side, rx_pop consumes rx_data
//   tx_data/tx_valid/tx_ready : UART transmit side, valid/ready handshake:
//                           a byte leaves the FIFO on a clock edge where
//                           tx_valid and tx_ready are both high
//   halt_out              : sticky stop flag set by a write to IO_STOP
// Optional feature: define CYCLE_COUNTER_EN for a free-running 32-bit cycle
// counter readable at IO_STOP..IO_STOP+3.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8    // must be a power of 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              rdy_out,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              halt_out
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Only mem_a[17:0] is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a[ADDR_W-1:18];

    logic              is_io;
    io_reg_e           io_reg;
    logic              tx_full;

    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] fifo_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halt_q, halt_d;
    // mem_din source: 1 = RAM read register, 0 = I/O read register
    logic              src_ram_q, src_ram_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

`ifdef CYCLE_COUNTER_EN
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       snap_q, snap_d;
`endif

    assign is_io   = (mem_a[17:16] == IO_SEL);
    assign io_reg  = decode_io_reg(mem_a[17:0]);
    assign tx_full = (count_q == CNT_W'(TX_DEPTH));
    assign rdy_out = !tx_full;

    always_comb begin
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        push       = 1'b0;
        push_data  = mem_dout;
        pop        = tx_valid && tx_ready;
        rx_pop     = 1'b0;
        halt_d     = halt_q;
        src_ram_d  = src_ram_q;
        io_rdata_d = io_rdata_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef CYCLE_COUNTER_EN
        cnt_d      = cnt_q + 32'd1;
        snap_d     = snap_q;
`endif

        // Every request is gated by rdy_out; a stalled request has no effect.
        if (rdy_out) begin
            if (!is_io) begin
                ram_we = mem_wr;
                ram_re = !mem_wr;
                if (!mem_wr) begin
                    src_ram_d = 1'b1;
                end
            end else if (mem_wr) begin
                if (mem_a[17:0] == IO_BASE[17:0]) begin
                    // A zero byte to the data register is dropped.
                    push = (mem_dout != 8'h00);
                end else if (mem_a[17:0] == IO_STOP[17:0]) begin
                    push      = 1'b1;
                    push_data = 8'h00;
                    halt_d    = 1'b1;
                end
            end else begin
                src_ram_d  = 1'b0;
                io_rdata_d = 8'h00;
                case (io_reg)
                    IO_RX: begin
                        if (rx_valid) begin
                            io_rdata_d = rx_data;
                            rx_pop     = !rst_in;
                        end
                    end
                    IO_CTR: begin
`ifdef CYCLE_COUNTER_EN
                        // Byte 0 takes a fresh snapshot; bytes 1..3 read it,
                        // so a 4-byte read sequence is self-consistent.
                        case (mem_a[1:0])
                            2'd0: begin
                                snap_d     = cnt_q;
                                io_rdata_d = cnt_q[7:0];
                            end
                            2'd1:    io_rdata_d = snap_q[15:8];
                            2'd2:    io_rdata_d = snap_q[23:16];
                            default: io_rdata_d = snap_q[31:24];
                        endcase
`endif
                    end
                    default: ;
                endcase
            end
        end

        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk_in) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            src_ram_q  <= 1'b0;
            io_rdata_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
            src_ram_q  <= src_ram_d;
            io_rdata_q <= io_rdata_d;
        end
    end

`ifdef CYCLE_COUNTER_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q  <= 32'd0;
            snap_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end
`endif

    byte_ram #(
        .ADDR_W (RAM_ADDR_WIDTH)
    ) u_byte_ram (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (mem_a[RAM_ADDR_WIDTH-1:0]),
        .wdata  (mem_dout),
        .rdata  (ram_rdata)
    );

    assign mem_din  = src_ram_q ? ram_rdata : io_rdata_q;
    assign tx_data  = fifo_mem_q[rd_ptr_q];
    assign tx_valid = (count_q != '0);
    assign halt_out = halt_q;

endmodule
